// File: rtl/fifo_rr_arbiter_if.sv
// Requester/FIFO-side signal bundle for fifo_rr_arbiter.
// The slave modport is the arbiter; the master modport is its environment (requesters and FIFO).
interface fifo_rr_arbiter_if #(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned ID_W = $clog2(N);

  logic [N-1:0]           req_valid;
  logic [N-1:0]           req_last;
  logic [N*DATA_W-1:0]    req_data;
  logic [N-1:0]           req_ready;
  logic                   fifo_write;
  logic [ID_W+DATA_W-1:0] fifo_data_in;
  logic                   fifo_full;
  logic [ID_W-1:0]        grant_id;
  logic                   busy;

  modport master (
    output req_valid, req_last, req_data, fifo_full,
    input  req_ready, fifo_write, fifo_data_in, grant_id, busy
  );

  modport slave (
    input  req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_write, fifo_data_in, grant_id, busy
  );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N requesters, with per-burst grant lock.
// Optional macro ARB_STATS_EN adds a saturating stall_cycles counter output.
module fifo_rr_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  fifo_rr_arbiter_if.slave    bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]         stall_cycles
`endif
);
  localparam int unsigned ID_W  = $clog2(N);
  localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {StIdle, StBurst} state_t;

  state_t            r_state;
  logic [ID_W-1:0]   r_last_grant;
  logic [ID_W-1:0]   r_grant_id;
  logic [CNT_W-1:0]  r_beat_cnt;

  logic [ID_W-1:0]   w_winner;
  logic [ID_W-1:0]   w_cand;
  logic              w_found;
  logic [DATA_W-1:0] w_gdata;
  logic              w_xfer;
  logic              w_at_max;
  logic              w_end;

  // Rotating priority: scan last_grant+1 .. last_grant+N modulo N.
  always_comb begin
    w_winner = '0;
    w_cand   = '0;
    w_found  = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_cand = ID_W'((32'(r_last_grant) + k) % N);
      if (!w_found && bus.req_valid[w_cand]) begin
        w_winner = w_cand;
        w_found  = 1'b1;
      end
    end
  end

  assign w_gdata  = bus.req_data[32'(r_grant_id)*DATA_W +: DATA_W];
  assign w_xfer   = (r_state == StBurst) & bus.req_valid[r_grant_id] & ~bus.fifo_full;
  assign w_at_max = (r_beat_cnt == CNT_W'(MAX_BURST - 1));
  assign w_end    = w_xfer & (bus.req_last[r_grant_id] | w_at_max);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_last_grant <= ID_W'(N - 1);
      r_grant_id   <= '0;
      r_beat_cnt   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (|bus.req_valid) begin
            r_state    <= StBurst;
            r_grant_id <= w_winner;
            r_beat_cnt <= '0;
          end
        end
        StBurst: begin
          if (w_end) begin
            r_state      <= StIdle;
            r_last_grant <= r_grant_id;
            r_beat_cnt   <= '0;
          end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (r_state == StBurst && !bus.fifo_full) begin
      bus.req_ready[r_grant_id] = 1'b1;
    end
  end

  assign bus.fifo_write   = w_xfer;
  assign bus.fifo_data_in = {r_grant_id, w_gdata};
  assign bus.grant_id     = r_grant_id;
  assign bus.busy         = (r_state == StBurst);

`ifdef ARB_STATS_EN
  logic [15:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stall_cycles <= '0;
    end else if (r_state == StBurst && bus.req_valid[r_grant_id] && bus.fifo_full &&
                 r_stall_cycles != 16'hFFFF) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif
endmodule
